// File: rtl/dcache_pkg.sv
// Shared types and field geometry for the L1 data-cache controller.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int INDEX_W   = 4;
    localparam int OFFSET_W  = 5;
    localparam int SEL_W     = 3;
    localparam int TAG_W     = 23;
    localparam int STAG_W    = 25;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_e;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a cache line and builds the same line with that word replaced.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LINE_W-1:0] line_o
);

    logic [7:0] bit_base;

    assign bit_base = {sel_i, 5'b0_0000};
    assign word_o   = line_i[bit_base +: WORD_W];

    always_comb begin
        line_o                      = line_i;
        line_o[bit_base +: WORD_W]  = word_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// L1 data-cache controller: hit detection, CPU stall, dirty-victim writeback and line refill
// against a 2-way LRU tag/data SRAM and a 256-bit memory port.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_data_i,
    input  logic                cpu_MemRead_i,
    input  logic                cpu_MemWrite_i,
    output logic [WORD_W-1:0]   cpu_data_o,
    output logic                cpu_stall_o,
    output logic [INDEX_W-1:0]  sram_addr_o,
    output logic [STAG_W-1:0]   sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    input  logic [STAG_W-1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
);

    state_e              state_q, state_d;
    logic                mem_enable_q, mem_enable_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_data_q, mem_data_d;

    logic                req;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    cpu_tag;
    logic [SEL_W-1:0]    word_sel;
    logic [WORD_W-1:0]   hit_word;
    logic [LINE_W-1:0]   merged_line;
    logic                unused_byte_offset;

    assign req                = cpu_MemRead_i | cpu_MemWrite_i;
    assign index              = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_tag            = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel           = cpu_addr_i[OFFSET_W-1:2];
    assign unused_byte_offset = ^cpu_addr_i[1:0];

    dcache_word_merge u_word_merge (
        .line_i (sram_data_i),
        .sel_i  (word_sel),
        .word_i (cpu_data_i),
        .word_o (hit_word),
        .line_o (merged_line)
    );

    assign cpu_data_o    = sram_hit_i ? hit_word : '0;
    assign cpu_stall_o   = req & ~((state_q == IDLE) & sram_hit_i);
    assign sram_enable_o = req;
    assign sram_addr_o   = index;

    assign mem_enable_o  = mem_enable_q;
    assign mem_write_o   = mem_write_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        sram_write_o = 1'b0;
        sram_tag_o   = {2'b00, cpu_tag};
        sram_data_o  = sram_data_i;

        unique case (state_q)
            IDLE: begin
                if (req && sram_hit_i && cpu_MemWrite_i) begin
                    sram_write_o = 1'b1;
                    sram_tag_o   = {2'b11, cpu_tag};
                    sram_data_o  = merged_line;
                end else if (req && !sram_hit_i) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_enable_d = 1'b1;
                // On a miss the SRAM presents the LRU victim, which is the way the refill replaces.
                if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                    state_d     = WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = line_addr(sram_tag_i[TAG_W-1:0], index);
                    mem_data_d  = sram_data_i;
                end else begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = line_addr(cpu_tag, index);
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = line_addr(cpu_tag, index);
                end
            end
            READMISS: begin
                if (mem_ack_i) begin
                    sram_write_o = 1'b1;
                    sram_tag_o   = {2'b10, cpu_tag};
                    sram_data_o  = mem_data_i;
                    mem_enable_d = 1'b0;
                    state_d      = READMISSOK;
                end
            end
            READMISSOK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

endmodule
